comparator_pipe: RTL and testbench
==================================

COMPARATOR_PIPE -- requirements
Module: comparator_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits, >= 4.
REQ-002 SHALL have parameter SLICE, default 4, bits resolved per pipeline stage; WIDTH SHALL be an integer multiple of SLICE.
REQ-003 SHALL have parameter CNT_W, default 16, width of each statistics counter.
REQ-004 Ports, one per line (name, direction, width, meaning):
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  pipeline accepts operand pair.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- sgn  input  1  1 = two's-complement compare, 0 = unsigned; sampled with A/B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- Y0  output  1  A < B.
- Y1  output  1  A == B.
- Y2  output  1  A > B.
- clr  input  1  synchronous clear of statistics counters.
- cnt_lt / cnt_eq / cnt_gt  output  CNT_W  result counters.

Function
REQ-005 Pipeline depth SHALL be N = WIDTH/SLICE stages; stage k resolves slice k counted from MSB.
REQ-006 Each stage SHALL carry a valid bit, remaining operand bits, a "decided" flag and a 2-bit partial result; a decided result SHALL pass unchanged through later stages.
REQ-007 If sgn=1, the MSB of both A and B SHALL be inverted before stage 0; all comparison thereafter is unsigned.
REQ-008 A stage not yet decided SHALL set decided when its slices differ, recording gt/lt; equal slices leave it undecided.
REQ-009 At the output stage, an undecided result SHALL yield Y1=1; exactly one of Y0/Y1/Y2 SHALL be 1 whenever out_valid=1.
REQ-010 Latency SHALL be N cycles from input handshake to out_valid (absent stall).
REQ-011 Global advance enable en = !out_valid || out_ready; in_ready SHALL equal en; all stages SHALL shift only when en=1.
REQ-012 Input handshake = in_valid && in_ready; output handshake = out_valid && out_ready.
REQ-013 When a bubble (valid=0) enters the output stage, Y0, Y1, Y2 SHALL all be 0.
REQ-014 While stalled (out_valid=1, out_ready=0), all outputs SHALL hold; no result SHALL be lost, duplicated or reordered.
REQ-015 Full throughput: one operand pair accepted per cycle while out_ready=1.

Reset
REQ-016 rst_n=0 SHALL asynchronously clear all stage valid bits, out_valid, Y0, Y1, Y2 and all counters to 0.
REQ-017 Reset mid-operation SHALL discard all in-flight results; in_ready SHALL be 1 during and after reset.
REQ-018 Operand data registers need no reset.

Configuration
REQ-019 Macro COMPARATOR_PIPE_STATS_EN defined: cnt_lt/cnt_eq/cnt_gt SHALL increment by 1 on each output handshake according to Y0/Y1/Y2, saturating at 2^CNT_W-1.
REQ-020 With macro defined: clr=1 SHALL zero all counters next edge; clr wins over a simultaneous increment.
REQ-021 Macro undefined: counter ports SHALL remain present and tied to 0, clr ignored, no counter registers instantiated.

Verification (WIDTH=16, SLICE=4, N=4 unless noted)
REQ-022 Unsigned: A=0x000A, B=0x0009, sgn=0 -> Y2=1, Y0=Y1=0, out_valid 4 cycles after handshake.
REQ-023 Signed: A=0xFFFF, B=0x0001, sgn=1 -> Y0=1; same operands sgn=0 -> Y2=1.
REQ-024 Equality/LSB slice: A=B=0x5A5A -> Y1=1; A=0x1230, B=0x1231 -> Y0=1; A=0x8000, B=0x7FFF, sgn=0 -> Y2=1 (decided at stage 0, held).
REQ-025 Backpressure: 6 back-to-back pairs, out_ready=0 for 3 cycles mid-stream -> in_ready=0 exactly while out_valid=1 and out_ready=0; all 6 results delivered in order.
REQ-026 Reset mid-op: rst_n=0 with 3 pairs in flight -> out_valid=0 and counters 0 immediately (before next edge); no stale result after release.
REQ-027 Stats (macro defined, CNT_W=4): 20 gt handshakes -> cnt_gt=15; clr asserted with a handshake -> all counters 0.

Source files
------------

// File: rtl/comparator_pipe.sv
// ---------------------------------------------------------------------------
// comparator_pipe
//
// Pipelined magnitude comparator. The operands are resolved SLICE bits per
// stage, starting at the MSB. There are N = WIDTH/SLICE stages, so the
// latency is N cycles and one operand pair can be accepted every cycle.
// Once a stage finds the first differing slice, its lt/gt verdict passes
// unchanged through all later stages. A pair that is still undecided after
// the last slice is reported as equal.
//
// Signed compare: the operand MSBs are inverted at the input. After that
// the whole compare is unsigned.
//
// Flow control: a single advance enable, en = !out_valid || out_ready,
// moves every stage together. in_ready is equal to en.
//
// Optional feature: define COMPARATOR_PIPE_STATS_EN to build three
// saturating result counters. clr clears them synchronously and takes
// priority over a counter increment. When the macro is not defined, the
// counter outputs are tied to zero and clr is ignored.
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   pipeline accepts an operand pair
//   A, B       operands, WIDTH bits
//   sgn        1 = two's-complement compare, 0 = unsigned (sampled with A/B)
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   Y0/Y1/Y2   A < B / A == B / A > B (all 0 while out_valid = 0)
//   clr        synchronous clear of the statistics counters
//   cnt_lt/cnt_eq/cnt_gt  result counters, CNT_W bits
// ---------------------------------------------------------------------------
module comparator_pipe #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sgn,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             Y0,
   output logic             Y1,
   output logic             Y2,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_lt,
   output logic [CNT_W-1:0] cnt_eq,
   output logic [CNT_W-1:0] cnt_gt
);

   localparam int N = WIDTH / SLICE;

   genvar gi;

   logic             en;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   // Inverting the sign bits maps two's-complement order onto unsigned order.
   assign a_in = {A[WIDTH-1] ^ sgn, A[WIDTH-2:0]};
   assign b_in = {B[WIDTH-1] ^ sgn, B[WIDTH-2:0]};

   // Stage gi receives IW unresolved bits and compares their top slice.
   // It passes only the bits that are still unresolved to the next stage,
   // so each stage register is smaller than the one before it.
   for (gi = 0; gi < N; gi++) begin : stg
      localparam int IW = WIDTH - gi * SLICE;

      logic [IW-1:0]    a_i;
      logic [IW-1:0]    b_i;
      logic             v_i;
      logic             d_i;
      logic [1:0]       r_i;     // {gt, lt}
      logic [SLICE-1:0] sa;
      logic [SLICE-1:0] sb;
      logic             v_q;
      logic             d_q;
      logic [1:0]       r_q;

      if (gi == 0) begin : g_src
         assign a_i = a_in;
         assign b_i = b_in;
         assign v_i = in_valid;
         assign d_i = 1'b0;
         assign r_i = 2'b00;
      end else begin : g_src
         assign a_i = stg[gi-1].g_rem.a_q;
         assign b_i = stg[gi-1].g_rem.b_q;
         assign v_i = stg[gi-1].v_q;
         assign d_i = stg[gi-1].d_q;
         assign r_i = stg[gi-1].r_q;
      end

      assign sa = a_i[IW-1 -: SLICE];
      assign sb = b_i[IW-1 -: SLICE];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_q <= 1'b0;
         end else if (en) begin
            v_q <= v_i;
         end
      end

      // The verdict does not need a reset: it is only observed through
      // v_q, which is reset.
      always_ff @(posedge clk) begin
         if (en) begin
            d_q <= d_i | (sa != sb);
            if (d_i) begin
               r_q <= r_i;
            end else if (sa > sb) begin
               r_q <= 2'b10;
            end else if (sa < sb) begin
               r_q <= 2'b01;
            end else begin
               r_q <= 2'b00;
            end
         end
      end

      if (gi < N - 1) begin : g_rem
         logic [IW-SLICE-1:0] a_q;
         logic [IW-SLICE-1:0] b_q;

         always_ff @(posedge clk) begin
            if (en) begin
               a_q <= a_i[IW-SLICE-1:0];
               b_q <= b_i[IW-SLICE-1:0];
            end
         end
      end
   end

   // The output stage is the last pipeline stage. Gating the flags with
   // valid makes all three flags 0 for a bubble.
   assign out_valid = stg[N-1].v_q;
   assign Y0 = stg[N-1].v_q &  stg[N-1].d_q & stg[N-1].r_q[0];
   assign Y1 = stg[N-1].v_q & ~stg[N-1].d_q;
   assign Y2 = stg[N-1].v_q &  stg[N-1].d_q & stg[N-1].r_q[1];

`ifdef COMPARATOR_PIPE_STATS_EN
   logic [2:0] hit;
   logic       out_hs;

   assign hit    = {Y2, Y1, Y0};
   assign out_hs = out_valid & out_ready;

   for (gi = 0; gi < 3; gi++) begin : g_cnt
      logic [CNT_W-1:0] q;

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            q <= '0;
         end else if (clr) begin
            q <= '0;
         end else if (out_hs && hit[gi] && (q != '1)) begin
            q <= q + CNT_W'(1);
         end
      end
   end

   assign cnt_lt = g_cnt[0].q;
   assign cnt_eq = g_cnt[1].q;
   assign cnt_gt = g_cnt[2].q;
`else
   logic unused_clr;

   assign unused_clr = clr;
   assign cnt_lt     = '0;
   assign cnt_eq     = '0;
   assign cnt_gt     = '0;
`endif

endmodule

// File: tb/tb_comparator_pipe.sv
// ---------------------------------------------------------------------------
// tb_comparator_pipe
//
// Self-checking bench for comparator_pipe (WIDTH=16, SLICE=4, CNT_W=4).
// A reference compare built on $signed/unsigned arithmetic feeds a queue
// of expected verdicts. Each accepted pair pushes one entry and each
// output handshake pops one. The expected counter values are held in a
// small saturating model.
// ---------------------------------------------------------------------------
module tb_comparator_pipe;

   localparam int WIDTH = 16;
   localparam int SLICE = 4;
   localparam int CNT_W = 4;
   localparam int N     = WIDTH / SLICE;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             sgn;
   logic             out_valid;
   logic             out_ready;
   logic             Y0, Y1, Y2;
   logic             clr;
   logic [CNT_W-1:0] cnt_lt, cnt_eq, cnt_gt;

   comparator_pipe #(.WIDTH(WIDTH), .SLICE(SLICE), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(A), .B(B), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready),
      .Y0(Y0), .Y1(Y1), .Y2(Y2), .clr(clr),
      .cnt_lt(cnt_lt), .cnt_eq(cnt_eq), .cnt_gt(cnt_gt)
   );

   always #5 clk = ~clk;

   int       n_checks = 0;
   int       n_fail   = 0;
   int       exp_q[$];
   int       m_cnt[3];
   int       stall_left = 0;
   bit       ready_base = 1'b1;
   bit       prev_stalled = 1'b0;
   logic [2:0] prev_y;
   bit       last_in_hs;
   logic     obs_valid;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // 0 = A<B, 1 = A==B, 2 = A>B
   function automatic int ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                  input bit s);
      if (s) begin
         if ($signed(a) < $signed(b)) return 0;
         if ($signed(a) > $signed(b)) return 2;
         return 1;
      end
      if (a < b) return 0;
      if (a > b) return 2;
      return 1;
   endfunction

   // One clock cycle: apply out_ready, sample everything, update the model,
   // then advance past the next rising edge.
   task automatic step();
      int  e;
      bit  out_hs;
      logic [2:0] exp_y;
      if (stall_left > 0) begin
         out_ready = 1'b0;
         stall_left--;
      end else begin
         out_ready = ready_base;
      end
      #1;
      obs_valid = out_valid;
      out_hs    = 1'b0;
      e         = 0;
      chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prev_stalled) chk("stall_hold", 32'({out_valid, Y0, Y1, Y2}), 32'({1'b1, prev_y}));
      chk("cnt_lt", 32'(cnt_lt), 32'(m_cnt[0]));
      chk("cnt_eq", 32'(cnt_eq), 32'(m_cnt[1]));
      chk("cnt_gt", 32'(cnt_gt), 32'(m_cnt[2]));
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            chk("spurious_out_valid", 32'(out_valid), 32'(0));
         end else begin
            e     = exp_q[0];
            exp_y = (e == 0) ? 3'b100 : (e == 1) ? 3'b010 : 3'b001;
            chk("result_Y0Y1Y2", 32'({Y0, Y1, Y2}), 32'(exp_y));
            if (out_ready) begin
               void'(exp_q.pop_front());
               out_hs = 1'b1;
            end
         end
      end else begin
         chk("bubble_Y0Y1Y2", 32'({Y0, Y1, Y2}), 32'(0));
      end
`ifdef COMPARATOR_PIPE_STATS_EN
      if (clr) begin
         m_cnt = '{0, 0, 0};
      end else if (out_hs && m_cnt[e] < CMAX) begin
         m_cnt[e]++;
      end
`endif
      last_in_hs = in_valid && in_ready;
      if (last_in_hs) exp_q.push_back(ref_cmp(A, B, sgn));
      prev_stalled = out_valid && !out_ready;
      prev_y       = {Y0, Y1, Y2};
      @(posedge clk);
      #1;
   endtask

   // Present a pair and hold it until it is accepted. in_valid stays high.
   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit s);
      bit done = 1'b0;
      A = a; B = b; sgn = s; in_valid = 1'b1;
      for (int i = 0; i < 20 && !done; i++) begin
         step();
         done = last_in_hs;
      end
      if (!done) chk("send_timeout", 32'(0), 32'(1));
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
      chk("drain_empty", 32'(exp_q.size()), 32'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WIDTH-1:0] ra, rb;
      int mode;
      m_cnt = '{0, 0, 0};
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; sgn = 1'b0; clr = 1'b0;
      #2;
      chk("reset_out_valid", 32'(out_valid), 32'(0));
      chk("reset_in_ready", 32'(in_ready), 32'(1));
      chk("reset_Y", 32'({Y0, Y1, Y2}), 32'(0));
      chk("reset_cnts", 32'({cnt_lt, cnt_eq, cnt_gt}), 32'(0));
      @(posedge clk); #3; rst_n = 1'b1;
      @(posedge clk); #1;

      // Latency: out_valid appears exactly N cycles after the handshake.
      send(16'h000A, 16'h0009, 1'b0);
      in_valid = 1'b0;
      for (int i = 1; i <= N; i++) begin
         step();
         chk($sformatf("latency_cyc%0d", i), 32'(obs_valid), 32'(i == N));
      end
      drain();

      // Directed operand pairs: signed/unsigned, equality, LSB slice, MSB slice.
      send(16'hFFFF, 16'h0001, 1'b1);
      send(16'hFFFF, 16'h0001, 1'b0);
      send(16'h5A5A, 16'h5A5A, 1'b0);
      send(16'h1230, 16'h1231, 1'b0);
      send(16'h8000, 16'h7FFF, 1'b0);
      send(16'h8000, 16'h7FFF, 1'b1);
      drain();

      // Backpressure: 6 back-to-back pairs, 3-cycle stall mid-stream.
      for (int i = 0; i < 6; i++) begin
         if (i == 4) stall_left = 3;
         send(16'(i * 16'h1111), 16'(16'h3333 + i), i[0]);
      end
      drain();

      // Randomised traffic with random backpressure.
      for (int i = 0; i < 400; i++) begin
         ra   = 16'($urandom);
         mode = $urandom_range(0, 3);
         case (mode)
            0: rb = 16'($urandom);
            1: rb = ra;
            2: rb = ra ^ (16'(1) << $urandom_range(0, 15));
            default: rb = {ra[15:4], 4'($urandom)};
         endcase
         A = ra; B = rb; sgn = 1'($urandom);
         in_valid   = ($urandom_range(0, 3) != 0);
         ready_base = ($urandom_range(0, 3) != 0);
         step();
      end
      ready_base = 1'b1;
      drain();

      // Reset in mid-operation: one result at the output, three in flight.
      for (int i = 0; i < N; i++) send(16'h0100 + 16'(i), 16'h00FF, 1'b0);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", 32'(out_valid), 32'(0));
      chk("midreset_Y", 32'({Y0, Y1, Y2}), 32'(0));
      chk("midreset_cnts", 32'({cnt_lt, cnt_eq, cnt_gt}), 32'(0));
      chk("midreset_in_ready", 32'(in_ready), 32'(1));
      exp_q.delete();
      m_cnt = '{0, 0, 0};
      prev_stalled = 1'b0;
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 2 * N; i++) step();

      // Saturation: 20 gt results, then clr coinciding with an output handshake.
      for (int i = 0; i < 20; i++) send(16'h0F00 + 16'(i), 16'h0E00, 1'b0);
      drain();
      for (int i = 0; i < N + 1; i++) begin
         clr = (i == N);
         send(16'h0001, 16'h0002, 1'b0);
      end
      clr = 1'b0;
      drain();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
